// File: rtl/jump_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : jump_unit_reserv_inf
// Purpose  : Reservation-entry bundle that the dispatcher drives into the jump unit
// Revision : 1.0
// ============================================================================
interface jump_unit_reserv_inf #(
    parameter int COMMON_W = 32,
    parameter int TAG_W    = 4
);
    logic [TAG_W-1:0]    target;
    logic [COMMON_W-1:0] val [1:2];
    logic [TAG_W-1:0]    tag;
    logic [COMMON_W-1:0] pc_addr;

    modport out (output target, val, tag, pc_addr);
    modport in  (input  target, val, tag, pc_addr);
endinterface
`default_nettype wire

// File: rtl/jump_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : jump_dispatch
// Purpose  : Accepts decoded JAL/JALR, binds a ROB tag, drives one-cycle jump-unit entries under credit flow control
// Revision : 1.0
// ============================================================================
module jump_dispatch #(
    parameter int               COMMON_W      = 32,
    parameter int               TAG_W         = 4,
    parameter logic [TAG_W-1:0] TAG_INVALID   = '1,
    parameter int               RES_ENTRY_NUM = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_is_jalr,
    input  logic [COMMON_W-1:0] in_pc,
    input  logic [COMMON_W-1:0] in_imm,
    input  logic [COMMON_W-1:0] in_rs1_val,
    input  logic [TAG_W-1:0]    in_rs1_tag,
    input  logic                rob_tag_valid,
    input  logic [TAG_W-1:0]    rob_tag,
    output logic                rob_alloc,
    input  logic [TAG_W-1:0]    issue_target,
    jump_unit_reserv_inf.out    new_entry,
    output logic                err_credit,
    output logic [31:0]         dispatch_cnt
);
    localparam int                C_CRED_W   = $clog2(RES_ENTRY_NUM + 1);
    localparam logic [C_CRED_W-1:0] C_CRED_MAX = C_CRED_W'(RES_ENTRY_NUM);

    logic [C_CRED_W-1:0] r_credits;
    logic                w_accept;
    logic                w_ret;
    logic [COMMON_W-1:0] w_val1;
    logic [COMMON_W-1:0] w_val2;
    logic [TAG_W-1:0]    w_tag;

    assign in_ready  = !rst && rob_tag_valid && (r_credits != '0);
    assign w_accept  = in_valid && in_ready;
    assign rob_alloc = w_accept;
    assign w_ret     = (issue_target != TAG_INVALID);

    // JALR val2 is imm-pc so the unit's pc+val1+val2 sum yields rs1+imm.
    always_comb begin
        w_val1 = '0;
        w_val2 = in_imm;
        w_tag  = TAG_INVALID;
        if (in_is_jalr) begin
            w_val2 = in_imm - in_pc;
            if (in_rs1_tag == TAG_INVALID) begin
                w_val1 = in_rs1_val;
            end else begin
                w_tag = in_rs1_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            new_entry.target  <= TAG_INVALID;
            new_entry.val[1]  <= '0;
            new_entry.val[2]  <= '0;
            new_entry.tag     <= TAG_INVALID;
            new_entry.pc_addr <= '0;
        end else if (w_accept) begin
            new_entry.target  <= rob_tag;
            new_entry.val[1]  <= w_val1;
            new_entry.val[2]  <= w_val2;
            new_entry.tag     <= w_tag;
            new_entry.pc_addr <= in_pc;
        end else begin
            new_entry.target  <= TAG_INVALID;
        end
    end

    // A return at full credit with no accept is a consumer protocol error; credit saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits    <= C_CRED_MAX;
            err_credit   <= 1'b0;
            dispatch_cnt <= '0;
        end else begin
            if (w_accept && !w_ret) begin
                r_credits <= r_credits - C_CRED_W'(1);
            end else if (!w_accept && w_ret) begin
                if (r_credits == C_CRED_MAX) begin
                    err_credit <= 1'b1;
                end else begin
                    r_credits <= r_credits + C_CRED_W'(1);
                end
            end
            if (w_accept) begin
                dispatch_cnt <= dispatch_cnt + 32'd1;
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/jump_dispatch.md
Name: jump_dispatch

Overview:
Dispatch-side driver of the jump unit reservation interface (jump_unit_reserv_inf, out modport). Accepts decoded JAL/JALR instructions from the decode/issue stage over a valid/ready handshake and binds the destination ROB tag. Forms the operand/tag/pc fields the jump unit expects and presents each entry for exactly one clock. Tracks free reservation entries with a credit counter, because the jump unit exposes no full signal.

Parameters:
COMMON_W, 32, data/address width (matches COMMON_WIDTH).
TAG_W, 4, ROB tag width (matches INST_TAG_WIDTH).
TAG_INVALID, all-ones of TAG_W (4'hF), codebase "no tag / no entry" encoding.
RES_ENTRY_NUM, 4, jump unit reservation entries; initial and maximum credit count.

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  decoded jump instruction present
in_ready  out  1  dispatcher can accept this cycle
in_is_jalr  in  1  1 = JALR, 0 = JAL
in_pc  in  COMMON_W  instruction address
in_imm  in  COMMON_W  sign-extended immediate
in_rs1_val  in  COMMON_W  rs1 value; meaningful only when in_rs1_tag == TAG_INVALID
in_rs1_tag  in  TAG_W  producer tag of rs1, or TAG_INVALID if the value is ready
rob_tag_valid  in  1  ROB has a free tag
rob_tag  in  TAG_W  tag offered by ROB for this instruction
rob_alloc  out  1  consume rob_tag (pulse, combinational)
issue_target  in  TAG_W  jump unit "target" output; not TAG_INVALID = one entry freed
new_entry  out  jump_unit_reserv_inf.out  fields target, val[1:2], tag, pc_addr
err_credit  out  1  sticky protocol error
dispatch_cnt  out  32  accepted-instruction count, wraps

Behaviour:
- Reset (async, while rst=1): new_entry.target=TAG_INVALID, val[1]=val[2]=0, tag=TAG_INVALID, pc_addr=0. credits=RES_ENTRY_NUM, err_credit=0, dispatch_cnt=0. in_ready=0 and rob_alloc=0 while rst=1.
- in_ready = !rst && rob_tag_valid && (credits != 0). in_ready has no dependence on in_valid.
- Accept = in_valid && in_ready, sampled at posedge. rob_alloc = accept (combinational, same cycle).
- On accept, the outputs are registered at that posedge and held for exactly one cycle. Latency is 1 cycle.
- Output fields on accept:
  - target = rob_tag; pc_addr = in_pc.
  - JAL: val[1]=0, tag=TAG_INVALID, val[2]=in_imm.
  - JALR with rs1 ready: val[1]=in_rs1_val, tag=TAG_INVALID.
  - JALR with rs1 pending: val[1]=0, tag=in_rs1_tag.
  - JALR val[2] = in_imm - in_pc, mod 2^COMMON_W. The jump unit computes pc+val1+val2, so the result is rs1+imm. No LSB clearing is done here.
- Posedge with no accept: target=TAG_INVALID; other fields hold their previous values (don't-care to the consumer).
- Back-to-back accepts: a new entry is driven every cycle, each for one full cycle. Each entry is stable across the consumer's negedge sample.
- Credits, evaluated at each posedge:
  - ret = (issue_target != TAG_INVALID); the consumer presents each freed target for one cycle.
  - Next credits = credits - accept + ret.
  - Simultaneous accept and ret: credits unchanged.
  - If ret arrives when credits == RES_ENTRY_NUM and there is no accept: credits stay at RES_ENTRY_NUM (saturate) and err_credit sets. err_credit stays set until rst.
  - Credits never go below 0, because accept requires credits != 0.
- dispatch_cnt increments by 1 per accept and wraps at 2^32.
- rst asserted mid-stream: any in-flight entry is dropped immediately (target=TAG_INVALID asynchronously). All state returns to reset values.
- No state machine beyond credit/output registers. State is {output register, credits (clog2(RES_ENTRY_NUM+1) bits), err_credit, dispatch_cnt}.

Test Plan:
1. Reset: pulse rst for 3 cycles mid-traffic, asynchronously to clk -> target=4'hF immediately, credits=4, err_credit=0, dispatch_cnt=0. After deassert with rob_tag_valid=1: in_ready=1.
2. JAL: pc=0x100, imm=0x20, rob_tag=3 -> rob_alloc=1 in the accept cycle. Next cycle: target=3, val1=0, val2=0x20, tag=4'hF, pc_addr=0x100. The cycle after: target=4'hF.
3. JALR, rs1 ready: pc=0x400, imm=8, rs1_val=0x2000 -> val1=0x2000, val2=0xFFFFFC08. Repeat with in_rs1_tag=5 -> tag=5, val1=0.
4. Credits: 4 back-to-back accepts with tags 0..3 and no returns -> 4 consecutive distinct targets; in_ready=0 on the 5th cycle. Then issue_target=2 for one cycle -> in_ready=1 the following cycle.
5. Simultaneous: at credits=1, accept and issue_target=1 in the same cycle -> credits stays 1, in_ready stays 1. Also: rob_tag_valid=0 -> in_ready=0, rob_alloc=0 regardless of in_valid.
6. Error: at credits=4 with no accept, issue_target=6 -> err_credit=1 (sticky), credits remains 4. dispatch_cnt equals the total number of accepts over the run.
